duty_button_conditioner: RTL and testbench
==========================================

// Module: duty_button_conditioner
// PURPOSE
//   Conditions the two raw duty-adjust push-buttons before the PWM generator sees them.
//   Per channel: 2-flop synchroniser, then counter debounce, then a one-cycle press pulse.
//   inc_pulse/dec_pulse drive the PWM generator's increase_duty/decrease_duty inputs directly.
//   Each pulse requests exactly one 10% duty step.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  cycles the synced input must hold a new level to be accepted (10 ms @ 100 MHz); >=2
//   REPEAT_DELAY     50_000_000 cycles from press pulse to first auto-repeat pulse (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD    20_000_000 cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//   clk          in   1  system clock, 100 MHz
//   rst_n        in   1  asynchronous active-low reset
//   ena          in   1  pulse enable; low suppresses pulse outputs
//   btn_inc_raw  in   1  raw asynchronous increase button, active high
//   btn_dec_raw  in   1  raw asynchronous decrease button, active high
//   inc_pulse    out  1  one-cycle increase request
//   dec_pulse    out  1  one-cycle decrease request
//   inc_level    out  1  debounced increase button level
//   dec_level    out  1  debounced decrease button level
// BEHAVIOUR
//   Reset (async assert, sync release)
//   - All sync flops, counters, levels and pulses go to 0. Reset mid-debounce discards the partial count.
//   Debounce, per channel
//   - cnt counts only while synced input != level.
//   - cnt clears to 0 in any cycle where synced input == level.
//   - When cnt == DEBOUNCE_CYCLES-1 and the inputs still differ: level toggles and cnt clears.
//   - Glitch shorter than DEBOUNCE_CYCLES: no level change.
//   - Counter width is $clog2(DEBOUNCE_CYCLES). It never wraps; it saturates by the clear.
//   Latency and pulse generation
//   - Raw high sampled at edge N: level rises at edge N+DEBOUNCE_CYCLES+2.
//   - Press pulse asserts in that same cycle, for exactly 1 cycle. Release generates no pulse.
//   Interlock
//   - inc_pulse requires dec_level==0 after update; dec_pulse requires inc_level==0 after update.
//   - Both levels rising in the same cycle: no pulse on either channel.
//   - inc_pulse and dec_pulse are never high together.
//   ena
//   - ena==0 forces both pulses to 0.
//   - Debounce and levels keep running while ena==0.
//   - No pulse is queued for re-issue when ena returns.
// CONFIGURATION
//   Macro AUTO_REPEAT_EN
//   - Defined:
//     - A per-channel repeat counter starts at the press pulse.
//     - While level stays high and the other level stays low, a pulse is issued REPEAT_DELAY cycles after the press pulse.
//     - Further pulses follow every REPEAT_PERIOD cycles.
//     - Release, or the other button's level going high, clears the repeat counter and stops repeats.
//     - ena and the interlock gate repeats exactly as they gate press pulses.
//   - Undefined: exactly one pulse per press; REPEAT_* parameters are unused.
// STRUCTURE
//   Package pwm_ctrl_pkg
//   - DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF and REPEAT_PERIOD_DEF localparams.
//   - Typedef for the debounce counter width.
//   Sub-module debounce_channel, instantiated twice
//   - Synchroniser, debounce counter, level register, rise strobe, optional repeat counter.
//   Top level
//   - Applies the interlock and ena gating.
//   - Registers inc_pulse/dec_pulse.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//   1. Reset then btn_inc_raw=1 held -> inc_level and inc_pulse rise 6 edges after first sample; inc_pulse high exactly 1 cycle.
//   2. btn_dec_raw high 3 cycles then low -> dec_level stays 0, no dec_pulse.
//   3. Both raw inputs raised on the same edge and held -> both levels rise together, zero pulses.
//   4. ena=0 during a press -> inc_level rises, no inc_pulse; ena=1 later -> still no pulse.
//   5. rst_n low after 2 debounce counts -> all outputs 0 immediately; after release, a fresh full 6-edge delay applies.
//   6. AUTO_REPEAT_EN, inc held -> pulses at press, +10, +15, +20; release -> no further pulses.
//      Without the macro: a single pulse only.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and types for the PWM duty-button conditioner.
// Holds default timing, the debounce counter type and the channel bundle.
package pwm_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int REPEAT_DELAY_DEF    = 50_000_000;
  localparam int REPEAT_PERIOD_DEF   = 20_000_000;

  localparam int DB_CNT_W_DEF = $clog2(DEBOUNCE_CYCLES_DEF);

  typedef logic [DB_CNT_W_DEF-1:0] db_cnt_t;

  // Registered per-channel status handed to the top level
  typedef struct packed {
    logic level;
    logic rise;
    logic rep;
  } chan_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop sync, counter debounce, level, rise strobe.
// Ports: clk, rst_n, raw, other_level in; st (level/rise/rep) out. AUTO_REPEAT_EN adds repeats.
module debounce_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  raw,
  input  logic  other_level,
  output chan_t st
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          level;
  logic          rise;
  logic          rep;
  logic          diff;
  logic          hit;

  assign diff = sync2 ^ level;
  assign hit  = diff && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Clearing on a match or on acceptance keeps cnt from wrapping
      if (!diff || hit)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (hit)
        level <= ~level;
      rise <= hit && !level;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = imax(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = $clog2(RMAX);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_on;
  logic          rpt_first;
  logic [RW-1:0] rpt_lim;

  assign rpt_lim = rpt_first ? RW'(REPEAT_DELAY - 1)
                             : RW'(REPEAT_PERIOD - 1);

  // Timing is anchored to the edge that sets rise, so repeats
  // land DELAY then PERIOD cycles after the press strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_on    <= 1'b0;
      rpt_first <= 1'b0;
      rep       <= 1'b0;
    end else if (hit && !level) begin
      rpt_cnt   <= '0;
      rpt_on    <= 1'b1;
      rpt_first <= 1'b1;
      rep       <= 1'b0;
    end else if (!rpt_on || !level || other_level) begin
      rpt_cnt   <= '0;
      rpt_on    <= 1'b0;
      rpt_first <= 1'b0;
      rep       <= 1'b0;
    end else if (rpt_cnt == rpt_lim) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
      rep       <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + RW'(1);
      rep       <= 1'b0;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = other_level
                    ^ (REPEAT_DELAY == REPEAT_PERIOD);
  assign rep = 1'b0;
`endif

  assign st = '{level: level, rise: rise, rep: rep};

endmodule

// File: rtl/duty_button_conditioner.sv
// Conditions inc/dec duty buttons into interlocked one-cycle pulses.
// Ports: clk, rst_n, ena, btn_*_raw in; *_pulse, *_level out. AUTO_REPEAT_EN enables auto-repeat.
module duty_button_conditioner
  import pwm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  chan_t inc_ch;
  chan_t dec_ch;
  logic  inc_req;
  logic  dec_req;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_inc (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (btn_inc_raw),
    .other_level (dec_ch.level),
    .st          (inc_ch)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_dec (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (btn_dec_raw),
    .other_level (inc_ch.level),
    .st          (dec_ch)
  );

  // A request needs the opposite level low after its own update;
  // a rising request implies its own level is high, so the two
  // pulses are mutually exclusive.
  assign inc_req = (inc_ch.rise | inc_ch.rep) & ~dec_ch.level;
  assign dec_req = (dec_ch.rise | dec_ch.rep) & ~inc_ch.level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      inc_level <= 1'b0;
      dec_level <= 1'b0;
    end else begin
      inc_pulse <= ena & inc_req;
      dec_pulse <= ena & dec_req;
      inc_level <= inc_ch.level;
      dec_level <= dec_ch.level;
    end
  end

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Scoreboard bench for duty_button_conditioner (DEBOUNCE=4, DELAY=10, PERIOD=5).
// Stimulus pushes expected pulse cycles; a monitor pops them when pulses appear.
module tb_duty_button_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic btn_inc_raw;
  logic btn_dec_raw;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_level;
  logic dec_level;

  typedef struct {
    int cyc;
    bit dec;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .btn_inc_raw (btn_inc_raw),
    .btn_dec_raw (btn_dec_raw),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .inc_level   (inc_level),
    .dec_level   (dec_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic act,
                       input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %b want %b",
               name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input bit d);
    exp_t e;
    e.cyc = c;
    e.dec = d;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (inc_pulse && dec_pulse) begin
      tests++;
      fails++;
      $display("FAIL both_pulses @cyc %0d: got 11 want not both",
               cyc);
    end else if (inc_pulse || dec_pulse) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse @cyc %0d: inc %b dec %b",
                 cyc, inc_pulse, dec_pulse);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.dec != dec_pulse) begin
          fails++;
          $display("FAIL pulse: got cyc %0d dec %b want cyc %0d dec %b",
                   cyc, dec_pulse, e.cyc, e.dec);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int p;
    rst_n       = 1'b0;
    ena         = 1'b1;
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inc_pulse", inc_pulse, 1'b0);
    check("rst_dec_pulse", dec_pulse, 1'b0);
    check("rst_inc_level", inc_level, 1'b0);
    check("rst_dec_level", dec_level, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Press inc and hold: press pulse 6 edges after first sample
    c = cyc;
    btn_inc_raw = 1'b1;
    p = c + 7;
    push(p, 1'b0);
`ifdef AUTO_REPEAT_EN
    push(p + 10, 1'b0);
    push(p + 15, 1'b0);
    push(p + 20, 1'b0);
`endif
    at_cyc(p - 1);
    check("t1_level_early", inc_level, 1'b0);
    at_cyc(p);
    check("t1_level_rise", inc_level, 1'b1);
    at_cyc(p + 15);
    btn_inc_raw = 1'b0;
    at_cyc(p + 21);
    check("t1_level_held", inc_level, 1'b1);
    at_cyc(p + 22);
    check("t1_level_fall", inc_level, 1'b0);
    at_cyc(p + 32);

    // Dec glitch of 3 samples: rejected
    c = cyc;
    btn_dec_raw = 1'b1;
    at_cyc(c + 3);
    btn_dec_raw = 1'b0;
    at_cyc(c + 7);
    check("t2_level_mid", dec_level, 1'b0);
    at_cyc(c + 12);
    check("t2_level_end", dec_level, 1'b0);

    // Both raised together: both levels rise, no pulses
    c = cyc;
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    at_cyc(c + 6);
    check("t3_inc_early", inc_level, 1'b0);
    at_cyc(c + 7);
    check("t3_inc_level", inc_level, 1'b1);
    check("t3_dec_level", dec_level, 1'b1);
    at_cyc(c + 10);
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    at_cyc(c + 20);
    check("t3_inc_low", inc_level, 1'b0);
    check("t3_dec_low", dec_level, 1'b0);

    // ena low over the press: level rises, pulse never issued
    c = cyc;
    ena = 1'b0;
    btn_inc_raw = 1'b1;
    at_cyc(c + 7);
    check("t4_level", inc_level, 1'b1);
    at_cyc(c + 8);
    ena = 1'b1;
    at_cyc(c + 9);
    btn_inc_raw = 1'b0;
    at_cyc(c + 26);
    check("t4_level_low", inc_level, 1'b0);

    // Reset mid-debounce discards the count
    c = cyc;
    btn_dec_raw = 1'b1;
    p = c + 7;
    push(p, 1'b1);
    at_cyc(p);
    check("t5_dec_level", dec_level, 1'b1);
    at_cyc(p + 1);
    btn_dec_raw = 1'b0;
    btn_inc_raw = 1'b1;
    at_cyc(p + 5);
    rst_n = 1'b0;
    #1;
    check("t5_rst_dec_level", dec_level, 1'b0);
    check("t5_rst_inc_level", inc_level, 1'b0);
    check("t5_rst_inc_pulse", inc_pulse, 1'b0);
    at_cyc(p + 7);
    rst_n = 1'b1;
    push(p + 14, 1'b0);
    at_cyc(p + 13);
    check("t5_inc_early", inc_level, 1'b0);
    at_cyc(p + 14);
    check("t5_inc_level", inc_level, 1'b1);
    at_cyc(p + 15);
    btn_inc_raw = 1'b0;
    at_cyc(p + 32);
    check("t5_inc_low", inc_level, 1'b0);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_pulse: got none want cyc %0d dec %b",
               e.cyc, e.dec);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
